// File: rtl/iterative_alu.sv
// ---------------------------------------------------------------------------
// iterative_alu
//
// Execute-stage ALU driven by the 4-bit alu_sel code from the ALU control
// decoder. Logic, arithmetic and compare operations complete in one cycle.
// Shifts walk one bit position per cycle, so a long shift stalls the pipeline
// through the valid/ready handshakes on both sides. Branch flags (zero,
// carry, overflow, sign) are produced alongside every result.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   in_valid       operation offered by the producer
//   in_ready       unit can accept an operation (only while IDLE)
//   alu_sel        operation code
//   op_a, op_b     operands (op_b also carries the shift amount / LUI value)
//   out_valid      result and flags are valid (DONE state)
//   out_ready      consumer takes the result
//   result         operation result
//   zero_flag      result == 0
//   carry_flag     carry-out for ADD, no-borrow for SUB
//   overflow_flag  signed overflow for ADD/SUB
//   sign_flag      result MSB
//   illegal_op     alu_sel was not a defined code
//   busy           unit is not IDLE
// ---------------------------------------------------------------------------
module iterative_alu #(
   parameter int XLEN = 32,
   parameter int SHW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_sel,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero_flag,
   output logic            carry_flag,
   output logic            overflow_flag,
   output logic            sign_flag,
   output logic            illegal_op,
   output logic            busy
);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_PASSB = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_XOR   = 4'b0111;
   localparam logic [3:0] OP_SLL   = 4'b1000;
   localparam logic [3:0] OP_SRL   = 4'b1001;
   localparam logic [3:0] OP_SRA   = 4'b1010;
   localparam logic [3:0] OP_SLT   = 4'b1101;
   localparam logic [3:0] OP_SLTU  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [XLEN-1:0]   work;
   logic [SHW-1:0]    count;
   logic [1:0]        shift_kind;

   logic              accept;
   logic              is_shift;
   logic [SHW-1:0]    shamt;

   logic [XLEN:0]     add_sum;
   logic [XLEN:0]     sub_sum;
   logic [XLEN-1:0]   alu_res;
   logic              alu_carry;
   logic              alu_ovf;
   logic              alu_ill;
   logic [XLEN-1:0]   shift_step;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign accept    = in_valid & in_ready;
   assign shamt     = op_b[SHW-1:0];
   assign is_shift  = (alu_sel == OP_SLL) || (alu_sel == OP_SRL) || (alu_sel == OP_SRA);

   // Single-cycle datapath on the live inputs. Only sampled in the accept
   // cycle, which is what makes later input changes irrelevant. SUB is done
   // as A + ~B + 1 so its carry-out reads directly as "no borrow". A shift
   // by zero degenerates to passing op_a straight through.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      alu_ill   = 1'b0;
      add_sum   = {1'b0, op_a} + {1'b0, op_b};
      sub_sum   = {1'b0, op_a} + {1'b0, ~op_b} + {{XLEN{1'b0}}, 1'b1};
      case (alu_sel)
         OP_ADD: begin
            alu_res   = add_sum[XLEN-1:0];
            alu_carry = add_sum[XLEN];
            alu_ovf   = (op_a[XLEN-1] == op_b[XLEN-1]) && (add_sum[XLEN-1] != op_a[XLEN-1]);
         end
         OP_SUB: begin
            alu_res   = sub_sum[XLEN-1:0];
            alu_carry = sub_sum[XLEN];
            alu_ovf   = (op_a[XLEN-1] != op_b[XLEN-1]) && (sub_sum[XLEN-1] != op_a[XLEN-1]);
         end
         OP_PASSB: alu_res = op_b;
         OP_OR:    alu_res = op_a | op_b;
         OP_AND:   alu_res = op_a & op_b;
         OP_XOR:   alu_res = op_a ^ op_b;
         OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
         OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         default:  alu_ill = 1'b1;
      endcase
   end

   // One-bit step of the iterative shifter. shift_kind is the low two bits
   // of the captured shift opcode: 00 SLL, 01 SRL, 10 SRA.
   always_comb begin
      shift_step = work;
      case (shift_kind)
         2'b00:   shift_step = {work[XLEN-2:0], 1'b0};
         2'b01:   shift_step = {1'b0, work[XLEN-1:1]};
         2'b10:   shift_step = {work[XLEN-1], work[XLEN-1:1]};
         default: shift_step = work;
      endcase
   end

   // Next-state logic. A shift with a non-zero amount spends exactly shamt
   // cycles in SHIFT; the cycle with count == 1 applies the last step and
   // moves to DONE, giving shamt+1 cycles from accept to out_valid.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_shift && (shamt != '0)) begin
                  state_next = SHIFT;
               end else begin
                  state_next = DONE;
               end
            end
         end
         SHIFT: begin
            if (count == SHW'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register. Reset drops any in-flight operation back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Result, flags and shifter working registers. Results load either at
   // accept (single-cycle ops and zero-length shifts) or on the final shift
   // step, and are otherwise held so DONE presents a stable value under
   // backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         result        <= '0;
         zero_flag     <= 1'b0;
         carry_flag    <= 1'b0;
         overflow_flag <= 1'b0;
         sign_flag     <= 1'b0;
         illegal_op    <= 1'b0;
         work          <= '0;
         count         <= '0;
         shift_kind    <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_shift && (shamt != '0)) begin
                     work       <= op_a;
                     count      <= shamt;
                     shift_kind <= alu_sel[1:0];
                  end else begin
                     result        <= alu_res;
                     zero_flag     <= (alu_res == '0);
                     carry_flag    <= alu_carry;
                     overflow_flag <= alu_ovf;
                     sign_flag     <= alu_res[XLEN-1];
                     illegal_op    <= alu_ill;
                  end
               end
            end
            SHIFT: begin
               work  <= shift_step;
               count <= count - SHW'(1);
               if (count == SHW'(1)) begin
                  result        <= shift_step;
                  zero_flag     <= (shift_step == '0);
                  carry_flag    <= 1'b0;
                  overflow_flag <= 1'b0;
                  sign_flag     <= shift_step[XLEN-1];
                  illegal_op    <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iterative_alu.sv
// ---------------------------------------------------------------------------
// tb_iterative_alu
//
// Self-checking bench for iterative_alu: a table of hand-derived vectors,
// randomized operations checked against a behavioural model, and hand-written
// sequences for backpressure and reset during a shift.
// ---------------------------------------------------------------------------
module tb_iterative_alu;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_sel;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero_flag;
   logic        carry_flag;
   logic        overflow_flag;
   logic        sign_flag;
   logic        illegal_op;
   logic        busy;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic [3:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expRes;
      logic        expZero;
      logic        expCarry;
      logic        expOvf;
      logic        expSign;
      logic        expIll;
      int          expLat;
   } vec_t;

   iterative_alu #(.XLEN(32), .SHW(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .alu_sel       (alu_sel),
      .op_a          (op_a),
      .op_b          (op_b),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .result        (result),
      .zero_flag     (zero_flag),
      .carry_flag    (carry_flag),
      .overflow_flag (overflow_flag),
      .sign_flag     (sign_flag),
      .illegal_op    (illegal_op),
      .busy          (busy)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mkVec(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] r, input logic z, input logic c, input logic v,
                                  input logic s, input logic il, input int lat);
      vec_t t;
      t.sel = sel; t.a = a; t.b = b; t.expRes = r;
      t.expZero = z; t.expCarry = c; t.expOvf = v; t.expSign = s; t.expIll = il; t.expLat = lat;
      return t;
   endfunction

   // Behavioural reference: plain arithmetic on wide signed/unsigned values
   // and the language shift operators.
   function automatic vec_t refModel(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
      vec_t   t;
      longint sa;
      longint sb;
      longint wideSigned;
      longint unsigned wideUns;
      int     sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % 32);
      t = mkVec(sel, a, b, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      case (sel)
         4'd0: begin
            wideUns = longint'(a) + longint'(b);
            t.expRes = wideUns[31:0];
            t.expCarry = (wideUns >= 64'd4294967296);
            wideSigned = sa + sb;
            t.expOvf = (wideSigned > 64'sd2147483647) || (wideSigned < -64'sd2147483648);
         end
         4'd1: begin
            t.expRes = a - b;
            t.expCarry = (a >= b);
            wideSigned = sa - sb;
            t.expOvf = (wideSigned > 64'sd2147483647) || (wideSigned < -64'sd2147483648);
         end
         4'd2:  t.expRes = b;
         4'd4:  t.expRes = a | b;
         4'd5:  t.expRes = a & b;
         4'd7:  t.expRes = a ^ b;
         4'd8:  t.expRes = a << sh;
         4'd9:  t.expRes = a >> sh;
         4'd10: t.expRes = $signed(a) >>> sh;
         4'd13: t.expRes = (sa < sb) ? 32'd1 : 32'd0;
         4'd15: t.expRes = (a < b) ? 32'd1 : 32'd0;
         default: t.expIll = 1'b1;
      endcase
      t.expZero = (t.expRes == 32'h0);
      t.expSign = t.expRes[31];
      if ((sel == 4'd8 || sel == 4'd9 || sel == 4'd10) && sh != 0) t.expLat = sh + 1;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one operation, scrambles the inputs right after the accept edge,
   // then counts cycles until out_valid. heldOff reports whether in_ready
   // stayed low and busy stayed high for the whole wait.
   task automatic applyStimulus(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output logic heldOff);
      int guard;
      guard = 0;
      while (!in_ready && guard < 100) begin
         tick();
         guard++;
      end
      if (guard >= 100) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      alu_sel  = sel;
      op_a     = a;
      op_b     = b;
      tick();
      in_valid = 1'b0;
      alu_sel  = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
      lat      = 1;
      heldOff  = 1'b1;
      while (!out_valid && lat < 100) begin
         if (in_ready || !busy) heldOff = 1'b0;
         tick();
         lat++;
      end
   endtask

   task automatic drainOutput();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic runVector(input string tag, input vec_t v);
      int   lat;
      logic heldOff;
      applyStimulus(v.sel, v.a, v.b, lat, heldOff);
      checkOutput({tag, "_latency"}, 32'(lat), 32'(v.expLat));
      checkOutput({tag, "_result"}, result, v.expRes);
      checkOutput({tag, "_zero"}, 32'(zero_flag), 32'(v.expZero));
      checkOutput({tag, "_carry"}, 32'(carry_flag), 32'(v.expCarry));
      checkOutput({tag, "_overflow"}, 32'(overflow_flag), 32'(v.expOvf));
      checkOutput({tag, "_sign"}, 32'(sign_flag), 32'(v.expSign));
      checkOutput({tag, "_illegal"}, 32'(illegal_op), 32'(v.expIll));
      if (v.expLat > 1) checkOutput({tag, "_stalled"}, 32'(heldOff), 32'd1);
      drainOutput();
      checkOutput({tag, "_idle_after"}, 32'(busy), 32'd0);
   endtask

   // Main sequence: reset checks, vector table, hand-written corner cases,
   // then randomized operations against the reference model.
   initial begin
      vec_t vecs[15];
      vec_t rv;
      int   lat;
      logic heldOff;
      logic stable;
      logic sawStale;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      alu_sel = 4'h0; op_a = 32'h0; op_b = 32'h0;

      vecs[0]  = mkVec(4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 1, 0, 1);
      vecs[1]  = mkVec(4'h1, 32'd5,         32'd5,         32'h0000_0000, 1, 1, 0, 0, 0, 1);
      vecs[2]  = mkVec(4'h1, 32'd3,         32'd5,         32'hFFFF_FFFE, 0, 0, 0, 1, 0, 1);
      vecs[3]  = mkVec(4'hD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 0, 0, 0, 0, 1);
      vecs[4]  = mkVec(4'hF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 0, 0, 0, 1);
      vecs[5]  = mkVec(4'hA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0, 0, 0, 1, 0, 5);
      vecs[6]  = mkVec(4'h9, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 0, 0, 0, 0, 0, 5);
      vecs[7]  = mkVec(4'h8, 32'hA5A5_A5A5, 32'h0000_0020, 32'hA5A5_A5A5, 0, 0, 0, 1, 0, 1);
      vecs[8]  = mkVec(4'h8, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 0, 0, 0, 1, 0, 32);
      vecs[9]  = mkVec(4'h3, 32'd123,       32'd456,       32'h0000_0000, 1, 0, 0, 0, 1, 1);
      vecs[10] = mkVec(4'h2, 32'h0000_0001, 32'hDEAD_0000, 32'hDEAD_0000, 0, 0, 0, 1, 0, 1);
      vecs[11] = mkVec(4'h4, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 0, 0, 0, 1, 0, 1);
      vecs[12] = mkVec(4'h5, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 0, 0, 0, 0, 0, 1);
      vecs[13] = mkVec(4'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0, 0, 0, 1);
      vecs[14] = mkVec(4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 0, 0, 1);

      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_result", result, 32'h0);
      checkOutput("reset_flags", {27'h0, zero_flag, carry_flag, overflow_flag, sign_flag, illegal_op}, 32'h0);

      foreach (vecs[i]) runVector($sformatf("vec%0d", i), vecs[i]);

      // Backpressure: hold the consumer off for 10 cycles while a new op is
      // offered; the result must not move and the offer must be ignored.
      applyStimulus(4'h0, 32'd10, 32'd20, lat, heldOff);
      checkOutput("bp_first_result", result, 32'd30);
      in_valid = 1'b1; alu_sel = 4'h1; op_a = 32'd100; op_b = 32'd1;
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (!out_valid || in_ready || result !== 32'd30 || zero_flag || carry_flag || sign_flag) stable = 1'b0;
      end
      checkOutput("bp_held_stable", 32'(stable), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
      checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      checkOutput("bp_next_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_next_result", result, 32'd99);
      checkOutput("bp_next_carry", 32'(carry_flag), 32'd1);
      drainOutput();

      // Reset seven cycles into a 20-bit shift: the operation must vanish.
      in_valid = 1'b1; alu_sel = 4'h8; op_a = 32'h0000_0003; op_b = 32'd20;
      tick();
      in_valid = 1'b0;
      repeat (7) tick();
      checkOutput("rst_mid_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_mid_result", result, 32'h0);
      sawStale = 1'b0;
      for (int c = 0; c < 25; c++) begin
         tick();
         if (out_valid) sawStale = 1'b1;
      end
      checkOutput("rst_mid_no_stale", 32'(sawStale), 32'd0);
      runVector("post_reset_add", refModel(4'h0, 32'h1234_5678, 32'h1111_1111));

      // Randomized operations over all sixteen codes.
      for (int n = 0; n < 40; n++) begin
         rv = refModel(4'($urandom_range(0, 15)), $urandom, $urandom);
         runVector($sformatf("rand%0d", n), rv);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
